// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-beat Wishbone classic initiator with valid/ready command and response ports; optional bus timeout via `define WBM_TIMEOUT_EN
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
  state_t r_state, w_next;
  logic   w_cmd_fire, w_ack, w_to, w_rsp_fire;
  // Gating with reset keeps cmd_ready_o low while reset is held, even though state already reads IDLE
  assign cmd_ready_o = wb_rst_ni && (r_state == IDLE);
  assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign w_ack       = (r_state == BUS) && wbm_ack_i;
  assign w_rsp_fire  = (r_state == RESP) && rsp_ready_i;
  assign wbm_stb_o   = wbm_cyc_o;
`ifdef WBM_TIMEOUT_EN
  logic [TO_W-1:0] r_cnt;
  // Count BUS cycles without ack; cleared as the cycle starts
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) r_cnt <= '0;
    else if (w_cmd_fire) r_cnt <= '0;
    else if (r_state == BUS && !wbm_ack_i) r_cnt <= r_cnt + TO_W'(1);
  // Terminal count fires on the edge that ends the TIMEOUT_CYCLES-th BUS cycle; ack takes priority
  assign w_to = (r_state == BUS) && !wbm_ack_i && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [TO_W-1:0] w_unused_to;
  assign w_unused_to = TO_W'(TIMEOUT_CYCLES);
  assign w_to        = 1'b0;
`endif
  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) r_state <= IDLE;
    else r_state <= w_next;
  // Next state: IDLE -> BUS on command, BUS -> RESP on ack or timeout, RESP -> IDLE on consume
  always_comb begin
    w_next = r_state;
    if (w_cmd_fire) w_next = BUS;
    else if (w_ack || w_to) w_next = RESP;
    else if (w_rsp_fire) w_next = IDLE;
  end
  // Bus and response registers; wbm_* hold their last values once the cycle ends
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      wbm_cyc_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        wbm_cyc_o <= 1'b1;
        wbm_we_o  <= cmd_we_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
        wbm_sel_o <= cmd_sel_i;
      end
      if (w_ack || w_to) begin
        wbm_cyc_o   <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_dat_o   <= (w_ack && !wbm_we_o) ? wbm_dat_i : '0;
        rsp_err_o   <= w_to;
      end
      if (w_rsp_fire) rsp_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b1, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack = 1'b0;
  logic [31:0] adr, dat_o, dat_i = '0;
  logic [3:0]  sel;
  int          n_cmp = 0, n_fail = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    chk("issue_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("issue_cyc", cyc, 1);
    chk("issue_stb", stb, 1);
    chk("issue_ready_low", cmd_ready, 0);
  endtask

  initial begin
    // 1 reset with cmd_valid asserted
    step(); step();
    chk("rst_cyc", cyc, 0);   chk("rst_stb", stb, 0);   chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);   chk("rst_dat", dat_o, 0); chk("rst_sel", sel, 0);
    chk("rst_rv", rsp_valid, 0); chk("rst_rdat", rsp_dat, 0); chk("rst_rerr", rsp_err, 0);
    chk("rst_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", cmd_ready, 1);
    chk("rel_cyc", cyc, 0);
    step();
    // 2 write, ack two cycles after cyc rises
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("wr_cyc", cyc, 1); chk("wr_we", we, 1); chk("wr_adr", adr, 32'h3000_0004);
      chk("wr_dat", dat_o, 32'hDEAD_BEEF); chk("wr_sel", sel, 4'hF); chk("wr_rv_low", rsp_valid, 0);
      if (i == 2) ack = 1'b1;
      step();
    end
    ack = 1'b0;
    chk("wr_cyc_end", cyc, 0); chk("wr_rv", rsp_valid, 1);
    chk("wr_rdat", rsp_dat, 0); chk("wr_rerr", rsp_err, 0);
    chk("wr_adr_hold", adr, 32'h3000_0004);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_rv_done", rsp_valid, 0); chk("wr_ready_back", cmd_ready, 1);
    // 3 read, zero-wait slave, response back-pressured for 4 cycles
    issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
    chk("rd_we", we, 0); chk("rd_sel", sel, 4'h3);
    ack = 1'b1; dat_i = 32'h1234_5678;
    step();
    ack = 1'b0; dat_i = 32'hFFFF_0000;
    chk("rd_cyc_end", cyc, 0); chk("rd_rv", rsp_valid, 1);
    chk("rd_rdat", rsp_dat, 32'h1234_5678); chk("rd_rerr", rsp_err, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_hold_rv", rsp_valid, 1); chk("rd_hold_dat", rsp_dat, 32'h1234_5678);
      chk("rd_hold_ready", cmd_ready, 0); chk("rd_hold_cyc", cyc, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_rv_done", rsp_valid, 0); chk("rd_ready_back", cmd_ready, 1);
    // 6 stray ack in IDLE
    ack = 1'b1; dat_i = 32'hCAFE_0000;
    step();
    ack = 1'b0;
    chk("stray_idle_cyc", cyc, 0); chk("stray_idle_rv", rsp_valid, 0);
    chk("stray_idle_ready", cmd_ready, 1); chk("stray_idle_dat", rsp_dat, 32'h1234_5678);
    // 6 stray ack in RESP
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    ack = 1'b1; dat_i = 32'hA5A5_0001;
    step();
    dat_i = 32'hFFFF_FFFF;
    step();
    ack = 1'b0;
    chk("stray_resp_rv", rsp_valid, 1); chk("stray_resp_dat", rsp_dat, 32'hA5A5_0001);
    chk("stray_resp_cyc", cyc, 0); chk("stray_resp_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("stray_resp_done", rsp_valid, 0);
`ifdef WBM_TIMEOUT_EN
    // 4 timeout: no ack, cyc high exactly 4 cycles
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      chk("to_cyc", cyc, 1);
      step();
    end
    chk("to_cyc_end", cyc, 0); chk("to_rv", rsp_valid, 1);
    chk("to_err", rsp_err, 1); chk("to_dat", rsp_dat, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    // 4 ack on the terminal cycle wins
    issue(1'b0, 32'h3000_0034, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      chk("toack_cyc", cyc, 1);
      if (i == 3) begin ack = 1'b1; dat_i = 32'h0000_0055; end
      step();
    end
    ack = 1'b0;
    chk("toack_rv", rsp_valid, 1); chk("toack_err", rsp_err, 0); chk("toack_dat", rsp_dat, 32'h55);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    // without the timeout the cycle waits indefinitely for ack
    issue(1'b1, 32'h3000_0030, 32'h1111_2222, 4'hF);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("wait_cyc", cyc, 1); chk("wait_rv", rsp_valid, 0);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("wait_rv_end", rsp_valid, 1); chk("wait_err", rsp_err, 0); chk("wait_cyc_end", cyc, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`endif
    // 5 reset mid-BUS
    issue(1'b1, 32'h3000_0040, 32'h0BAD_F00D, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", cyc, 0); chk("mid_rst_stb", stb, 0); chk("mid_rst_adr", adr, 0);
    chk("mid_rst_rv", rsp_valid, 0); chk("mid_rst_ready", cmd_ready, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", cmd_ready, 1); chk("mid_rel_rv", rsp_valid, 0);
    step();
    chk("mid_no_rsp", rsp_valid, 0);
    issue(1'b1, 32'h3000_0044, 32'h5555_AAAA, 4'hC);
    chk("after_adr", adr, 32'h3000_0044); chk("after_dat", dat_o, 32'h5555_AAAA);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("after_rv", rsp_valid, 1); chk("after_err", rsp_err, 0); chk("after_rdat", rsp_dat, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("after_done", rsp_valid, 0); chk("after_ready", cmd_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
